// File: rtl/pipeline_pkg.sv
// ============================================================================
//  Module  : pipeline_pkg
//  Brief   : Shared opcode decode and hazard-controller state type.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package pipeline_pkg;

    localparam logic [6:0] OPCODE_NOP = 7'b0100000;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDSTALL = 2'd1,
        FLUSH   = 2'd2
    } hazard_state_e;

    function automatic logic uses_rn(input logic [6:0] op);
        if (op == OPCODE_NOP) return 1'b0;
        return (!op[6] && (op[3:0] != 4'd0)) || (op[6:5] == 2'b11);
    endfunction

    function automatic logic uses_rm(input logic [6:0] op);
        if (op == OPCODE_NOP) return 1'b0;
        return (!op[6] && op[4]) ||
               ((op[6:5] == 2'b11) && op[3]) ||
               ((op[6:2] == 5'b10010) && op[0]);
    endfunction

    function automatic logic uses_rs(input logic [6:0] op);
        if (op == OPCODE_NOP) return 1'b0;
        return op[6:4] == 3'b011;
    endfunction

    // LDR (register form) or LDR literal
    function automatic logic is_load(input logic [6:0] op);
        return ((op[6:5] == 2'b11) && op[0]) || (op[6:3] == 4'b1000);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
//  Module  : sat_counter
//  Brief   : Up-counter that sticks at all-ones instead of wrapping.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] c_one = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_q <= count_q + c_one;
        end
    end

    assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
//  Module  : pipeline_hazard_ctrl
//  Brief   : Load-use interlock and taken-branch squash sequencer with perf counters.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int LOAD_STALL_CYCLES   = 2,
    parameter int BRANCH_FLUSH_CYCLES = 2,
    parameter int CNT_W               = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode_execute,
    input  logic [3:0]       rn_execute,
    input  logic [3:0]       rm_execute,
    input  logic [3:0]       rs_execute,
    input  logic [6:0]       opcode_memory,
    input  logic [3:0]       rd_memory,
    input  logic             branch_taken,
    output logic             stall_pc,
    output logic             sel_stall,
    output logic             bubble_memory,
    output logic             flush_front,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_cycles
);

    localparam int c_max_cycles = (LOAD_STALL_CYCLES > BRANCH_FLUSH_CYCLES) ?
                                  LOAD_STALL_CYCLES : BRANCH_FLUSH_CYCLES;
    // cnt only ever holds values up to max-2
    localparam int c_cw = (c_max_cycles > 2) ? $clog2(c_max_cycles - 1) : 1;

    localparam logic [c_cw-1:0] c_ld_init  = c_cw'(LOAD_STALL_CYCLES - 2);
    localparam logic [c_cw-1:0] c_br_init  = c_cw'(BRANCH_FLUSH_CYCLES - 2);
    localparam logic [c_cw-1:0] c_cnt_one  = {{(c_cw-1){1'b0}}, 1'b1};

    hazard_state_e   state_q, state_d;
    logic [c_cw-1:0] cnt_q, cnt_d;
    logic            load_use;
    logic            stall_raw, flush_raw;

    always_comb begin
        load_use = is_load(opcode_memory) && (
                   (uses_rn(opcode_execute) && (rn_execute == rd_memory)) ||
                   (uses_rm(opcode_execute) && (rm_execute == rd_memory)) ||
                   (uses_rs(opcode_execute) && (rs_execute == rd_memory)));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A load-use hazard outranks a branch: the branch operand is not valid yet.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall_raw = 1'b0;
        flush_raw = 1'b0;
        case (state_q)
            RUN: begin
                if (load_use) begin
                    stall_raw = 1'b1;
                    if (LOAD_STALL_CYCLES > 1) begin
                        state_d = LDSTALL;
                        cnt_d   = c_ld_init;
                    end
                end else if (branch_taken) begin
                    flush_raw = 1'b1;
                    if (BRANCH_FLUSH_CYCLES > 1) begin
                        state_d = FLUSH;
                        cnt_d   = c_br_init;
                    end
                end
            end
            LDSTALL: begin
                stall_raw = 1'b1;
                if (cnt_q == '0) state_d = RUN;
                else             cnt_d   = cnt_q - c_cnt_one;
            end
            FLUSH: begin
                flush_raw = 1'b1;
                if (cnt_q == '0) state_d = RUN;
                else             cnt_d   = cnt_q - c_cnt_one;
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    assign stall_pc      = rst_n & stall_raw;
    assign sel_stall     = rst_n & stall_raw;
    assign bubble_memory = rst_n & stall_raw;
    assign flush_front   = rst_n & flush_raw;
    assign busy          = rst_n & (state_q != RUN);

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (sel_stall),
        .count (stall_cycles)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_front),
        .count (flush_cycles)
    );

endmodule

`default_nettype wire
